// File: rtl/uart_mm_cmd_bridge.sv
// uart_mm_cmd_bridge: parses command frames from a UART byte stream and runs
// single-word Avalon-MM writes/reads. It answers each frame with an ack, the
// read data, or an error byte.
// Frame: CMD(0x57 write / 0x52 read), ADDR[31:0] MSB first, then DATA[31:0]
// MSB first for writes.
// Optional build macro UART_MM_CMD_BRIDGE_CHECKSUM_EN: each frame carries one
// trailing XOR checksum byte covering CMD and every following frame byte.
module uart_mm_cmd_bridge #(
  parameter int INTER_BYTE_TIMEOUT = 100000,
  parameter int BUS_TIMEOUT        = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] master_mm_address,
  output logic        master_mm_write,
  output logic [31:0] master_mm_writedata,
  output logic        master_mm_read,
  input  logic [31:0] master_mm_readdata,
  input  logic        master_mm_readdatavalid,
  input  logic        master_mm_waitrequest,
  output logic        msg_done,
  output logic        busy,
  output logic        rx_drop
);

  localparam int IB_W = $clog2(INTER_BYTE_TIMEOUT + 1);
  localparam int BT_W = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0]  CMD_WR   = 8'h57;
  localparam logic [7:0]  CMD_RD   = 8'h52;
  localparam logic [31:0] RESP_ACK = {8'h4B, 24'h0};
  localparam logic [31:0] RESP_ERR = {8'h45, 24'h0};

`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
  localparam logic [31:0] RESP_CSUM = {8'h43, 24'h0};
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_WAIT_RD, S_RESP, S_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS_WR, S_BUS_RD, S_WAIT_RD, S_RESP
  } state_t;
`endif

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      resp_q;       // response bytes, next one to send in [31:24]
  logic [2:0]       resp_cnt_q;   // response bytes still to be accepted
  logic [1:0]       byte_cnt_q;   // byte position within ADDR or DATA field
  logic             is_wr_q;
  logic [IB_W-1:0]  ib_cnt_q;
  logic [BT_W-1:0]  bus_cnt_q;
  logic             wr_q;
  logic             rd_q;
  logic             tx_valid_q;
  logic             msg_done_q;
  logic             rx_drop_q;
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
  logic [7:0]       csum_q;
  logic [7:0]       csum_d;
`endif

  logic [31:0]      addr_d;
  logic [31:0]      wdata_d;
  logic [IB_W-1:0]  ib_cnt_d;
  logic [BT_W-1:0]  bus_cnt_d;
  logic             ib_expired;
  logic             bus_expired;
  logic             rx_discard;

  assign addr_d      = {addr_q[23:0], rx_data};
  assign wdata_d     = {wdata_q[23:0], rx_data};
  assign ib_cnt_d    = ib_cnt_q + IB_W'(1);
  assign bus_cnt_d   = bus_cnt_q + BT_W'(1);
  // Timers start at 0 on entry, so the Nth idle/bus cycle is the one that expires.
  assign ib_expired  = (ib_cnt_d == IB_W'(INTER_BYTE_TIMEOUT));
  assign bus_expired = (bus_cnt_d == BT_W'(BUS_TIMEOUT));
  assign rx_discard  = (state_q == S_BUS_WR) || (state_q == S_BUS_RD) ||
                       (state_q == S_WAIT_RD) || (state_q == S_RESP);
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
  assign csum_d      = csum_q ^ rx_data;
`endif

  assign tx_data             = resp_q[31:24];
  assign tx_valid            = tx_valid_q;
  assign master_mm_address   = addr_q;
  assign master_mm_writedata = wdata_q;
  assign master_mm_write     = wr_q;
  assign master_mm_read      = rd_q;
  assign msg_done            = msg_done_q;
  assign rx_drop             = rx_drop_q;
  assign busy                = (state_q != S_IDLE);

  // Command FSM: frame assembly, bus cycle, response sequencing and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
      byte_cnt_q <= '0;
      is_wr_q    <= 1'b0;
      ib_cnt_q   <= '0;
      bus_cnt_q  <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      msg_done_q <= 1'b0;
      rx_drop_q  <= 1'b0;
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      msg_done_q <= 1'b0;
      rx_drop_q  <= rx_valid && rx_discard;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt_q <= '0;
            ib_cnt_q   <= '0;
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              is_wr_q <= (rx_data == CMD_WR);
              state_q <= S_ADDR;
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
              csum_q  <= rx_data;
`endif
            end else begin
              resp_q     <= RESP_ERR;
              resp_cnt_q <= 3'd1;
              tx_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q     <= addr_d;
            ib_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_q <= S_DATA;
              end else begin
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
                state_q <= S_CSUM;
`else
                rd_q      <= 1'b1;
                bus_cnt_q <= '0;
                state_q   <= S_BUS_RD;
`endif
              end
            end
          end else if (ib_expired) begin
            state_q <= S_IDLE;
          end else begin
            ib_cnt_q <= ib_cnt_d;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            wdata_q    <= wdata_d;
            ib_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
            csum_q     <= csum_d;
            if (byte_cnt_q == 2'd3) state_q <= S_CSUM;
`else
            if (byte_cnt_q == 2'd3) begin
              wr_q      <= 1'b1;
              bus_cnt_q <= '0;
              state_q   <= S_BUS_WR;
            end
`endif
          end else if (ib_expired) begin
            state_q <= S_IDLE;
          end else begin
            ib_cnt_q <= ib_cnt_d;
          end
        end
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
        S_CSUM: begin
          if (rx_valid) begin
            if (rx_data != csum_q) begin
              resp_q     <= RESP_CSUM;
              resp_cnt_q <= 3'd1;
              tx_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end else if (is_wr_q) begin
              wr_q      <= 1'b1;
              bus_cnt_q <= '0;
              state_q   <= S_BUS_WR;
            end else begin
              rd_q      <= 1'b1;
              bus_cnt_q <= '0;
              state_q   <= S_BUS_RD;
            end
          end else if (ib_expired) begin
            state_q <= S_IDLE;
          end else begin
            ib_cnt_q <= ib_cnt_d;
          end
        end
`endif
        S_BUS_WR: begin
          // Acceptance wins over a timeout landing on the same cycle.
          if (!master_mm_waitrequest) begin
            wr_q       <= 1'b0;
            resp_q     <= RESP_ACK;
            resp_cnt_q <= 3'd1;
            tx_valid_q <= 1'b1;
            msg_done_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (bus_expired) begin
            wr_q       <= 1'b0;
            resp_q     <= RESP_ERR;
            resp_cnt_q <= 3'd1;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            bus_cnt_q <= bus_cnt_d;
          end
        end
        S_BUS_RD: begin
          if (!master_mm_waitrequest) begin
            rd_q <= 1'b0;
            if (master_mm_readdatavalid) begin
              resp_q     <= master_mm_readdata;
              resp_cnt_q <= 3'd4;
              tx_valid_q <= 1'b1;
              msg_done_q <= 1'b1;
              state_q    <= S_RESP;
            end else if (bus_expired) begin
              resp_q     <= RESP_ERR;
              resp_cnt_q <= 3'd1;
              tx_valid_q <= 1'b1;
              state_q    <= S_RESP;
            end else begin
              bus_cnt_q <= bus_cnt_d;
              state_q   <= S_WAIT_RD;
            end
          end else if (bus_expired) begin
            rd_q       <= 1'b0;
            resp_q     <= RESP_ERR;
            resp_cnt_q <= 3'd1;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            bus_cnt_q <= bus_cnt_d;
          end
        end
        S_WAIT_RD: begin
          // readdatavalid is only sampled here and in BUS_RD, so a late one
          // after a timeout is ignored.
          if (master_mm_readdatavalid) begin
            resp_q     <= master_mm_readdata;
            resp_cnt_q <= 3'd4;
            tx_valid_q <= 1'b1;
            msg_done_q <= 1'b1;
            state_q    <= S_RESP;
          end else if (bus_expired) begin
            resp_q     <= RESP_ERR;
            resp_cnt_q <= 3'd1;
            tx_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            bus_cnt_q <= bus_cnt_d;
          end
        end
        S_RESP: begin
          // tx_valid is high for the whole of RESP; shift only on acceptance.
          if (tx_ready) begin
            if (resp_cnt_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              resp_q     <= {resp_q[23:0], 8'h00};
              resp_cnt_q <= resp_cnt_q - 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mm_cmd_bridge.sv
// Scoreboard bench for uart_mm_cmd_bridge: stimulus pushes expected tx bytes
// and bus transactions; negedge monitors pop and compare.
module tb_uart_mm_cmd_bridge;

  localparam int IBT = 40;
  localparam int BT  = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [31:0] mm_addr;
  logic        mm_write;
  logic [31:0] mm_wdata;
  logic        mm_read;
  logic [31:0] mm_rdata = '0;
  logic        mm_rdv = 1'b0;
  logic        mm_wait = 1'b0;
  logic        msg_done;
  logic        busy;
  logic        rx_drop;

  uart_mm_cmd_bridge #(.INTER_BYTE_TIMEOUT(IBT), .BUS_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .master_mm_address(mm_addr), .master_mm_write(mm_write),
    .master_mm_writedata(mm_wdata), .master_mm_read(mm_read),
    .master_mm_readdata(mm_rdata), .master_mm_readdatavalid(mm_rdv),
    .master_mm_waitrequest(mm_wait),
    .msg_done(msg_done), .busy(busy), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] hold;
  } bus_t;

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tx_acc = 0;
  int msg_cnt = 0;
  int drop_cnt = 0;
  int hold_cnt = 0;

  // slave / sink configuration
  int          stall_cfg = 0;
  int          stall_cnt = 0;
  bit          rd_respond = 1'b0;
  logic [31:0] rd_word = '0;
  bit          rd_pending = 1'b0;
  int          tx_stall_at = -1;
  int          tx_stall_left = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave and tx sink: drive responses just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      mm_rdv = 1'b0;
      if (rd_pending) begin
        mm_rdv     = 1'b1;
        mm_rdata   = rd_word;
        rd_pending = 1'b0;
      end
      if (mm_write || mm_read) begin
        if (stall_cnt < stall_cfg) begin
          mm_wait = 1'b1;
          stall_cnt++;
        end else begin
          mm_wait = 1'b0;
          if (mm_read && rd_respond) rd_pending = 1'b1;
        end
      end else begin
        mm_wait   = 1'b0;
        stall_cnt = 0;
      end
      if (tx_valid && tx_acc == tx_stall_at && tx_stall_left > 0) begin
        tx_ready = 1'b0;
        tx_stall_left--;
      end else begin
        tx_ready = 1'b1;
      end
    end
  end

  // Monitors: tx bytes, bus transactions, pulses.
  always @(negedge clk) begin
    if (rst) begin
      hold_cnt   = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_stable", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) fail_now("tx_unexpected", {24'd0, tx_data});
        else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
        tx_acc++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;

      if (mm_write && mm_read) fail_now("rd_wr_together", 32'd3);
      if (mm_write || mm_read) hold_cnt++;
      if ((mm_write || mm_read) && !mm_wait) begin
        if (exp_bus.size() == 0) begin
          fail_now("bus_unexpected", mm_addr);
        end else begin
          bus_t e;
          e = exp_bus.pop_front();
          chk("bus_is_write", {31'd0, mm_write}, {31'd0, e.we});
          chk("bus_addr", mm_addr, e.addr);
          if (e.we) chk("bus_wdata", mm_wdata, e.data);
          chk("bus_hold_cycles", hold_cnt, {16'd0, e.hold});
        end
        hold_cnt = 0;
      end
      if (!(mm_write || mm_read)) hold_cnt = 0;

      if (msg_done) begin
        msg_cnt++;
        chk("msg_done_with_tx", {31'd0, tx_valid}, 32'd1);
      end
      if (rx_drop) drop_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [31:0] data);
    logic [7:0] cs;
    cs = cmd;
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) begin
      send_byte(addr[i*8 +: 8]);
      cs = cs ^ addr[i*8 +: 8];
    end
    if (cmd == 8'h57) begin
      for (int i = 3; i >= 0; i--) begin
        send_byte(data[i*8 +: 8]);
        cs = cs ^ data[i*8 +: 8];
      end
    end
`ifdef UART_MM_CMD_BRIDGE_CHECKSUM_EN
    send_byte(cs);
`endif
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_tx.push_back(w[i*8 +: 8]);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [15:0] h);
    bus_t e;
    e.we = we; e.addr = a; e.data = d; e.hold = h;
    exp_bus.push_back(e);
  endtask

  // Wait for the transaction to drain, bounded; then the queues must be empty.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy || tx_valid || exp_tx.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) fail_now({name, "_timeout"}, n);
    chk({name, "_tx_left"}, exp_tx.size(), 0);
    chk({name, "_bus_left"}, exp_bus.size(), 0);
  endtask

  initial begin
    int msg_exp;
    int t0;
    int n;
    msg_exp = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_write", {31'd0, mm_write}, 32'd0);
    chk("rst_read", {31'd0, mm_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_msg_done", {31'd0, msg_done}, 32'd0);
    chk("rst_rx_drop", {31'd0, rx_drop}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: write with 3 wait states
    stall_cfg = 3;
    push_bus(1'b1, 32'h4, 32'hDEADBEEF, 16'd4);
    exp_tx.push_back(8'h4B);
    msg_exp++;
    send_frame(8'h57, 32'h4, 32'hDEADBEEF);
    wait_done("write");
    chk("write_msg_count", msg_cnt, msg_exp);

    // 2: read back, data one cycle after acceptance, sink stalls on byte 2
    stall_cfg  = 0;
    rd_respond = 1'b1;
    rd_word    = 32'hDEADBEEF;
    tx_stall_at   = tx_acc + 1;
    tx_stall_left = 5;
    push_bus(1'b0, 32'h4, 32'h0, 16'd1);
    push_word(32'hDEADBEEF);
    msg_exp++;
    send_frame(8'h52, 32'h4, 32'h0);
    wait_done("readback");
    chk("readback_msg_count", msg_cnt, msg_exp);

    // 3: unmapped read, no readdatavalid -> error after BUS_TIMEOUT cycles
    rd_respond = 1'b0;
    push_bus(1'b0, 32'hC, 32'h0, 16'd1);
    exp_tx.push_back(8'h45);
    send_frame(8'h52, 32'hC, 32'h0);
    @(negedge clk);
    chk("unmapped_read_asserted", {31'd0, mm_read}, 32'd1);
    t0 = cyc;
    n = 0;
    while (!tx_valid && n < 4 * BT) begin
      @(negedge clk);
      n++;
    end
    chk("unmapped_err_latency", cyc - t0, BT);
    chk("unmapped_read_dropped", {31'd0, mm_read}, 32'd0);
    wait_done("unmapped");
    chk("unmapped_msg_count", msg_cnt, msg_exp);

    // 4: bad command, then a write to address 0
    exp_tx.push_back(8'h45);
    send_byte(8'h11);
    wait_done("badcmd");
    push_bus(1'b1, 32'h0, 32'h1, 16'd1);
    exp_tx.push_back(8'h4B);
    msg_exp++;
    send_frame(8'h57, 32'h0, 32'h1);
    wait_done("write0");
    chk("write0_msg_count", msg_cnt, msg_exp);

    // 5a: partial frame aborted by the inter-byte timeout
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (IBT - 1) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("abort_busy_after", {31'd0, busy}, 32'd0);
    chk("abort_no_tx", {31'd0, tx_valid}, 32'd0);
    wait_done("abort");

    // 5b: rx byte during RESP is dropped, response unaffected
    tx_stall_at   = tx_acc;
    tx_stall_left = 8;
    exp_tx.push_back(8'h45);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    chk("drop_pulse", {31'd0, rx_drop}, 32'd1);
    wait_done("drop");
    chk("drop_count", drop_cnt, 1);

    // 6: reset while a write is stuck on waitrequest, then a normal read
    stall_cfg = 1000;
    send_frame(8'h57, 32'h8, 32'h12345678);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_write", {31'd0, mm_write}, 32'd0);
    chk("rstmid_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_msg_done", {31'd0, msg_done}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    stall_cfg  = 0;
    rd_respond = 1'b1;
    rd_word    = 32'hCAFEF00D;
    push_bus(1'b0, 32'h4, 32'h0, 16'd1);
    push_word(32'hCAFEF00D);
    msg_exp++;
    send_frame(8'h52, 32'h4, 32'h0);
    wait_done("post_reset_read");

    chk("final_msg_count", msg_cnt, msg_exp);
    chk("final_drop_count", drop_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mm_cmd_bridge.md
Name: uart_mm_cmd_bridge

Overview:
Byte-stream command parser that acts as an Avalon-MM master for the LED blinker register block, sitting directly upstream of it. Consumes command frames from the UART receive byte stream and issues single-word register writes and reads. Returns one ack, read-data or error response over the UART transmit byte stream. Emits a one-cycle pulse per successfully completed command, which drives the blinker's message-counter input.

Parameters:
INTER_BYTE_TIMEOUT, 100000, max idle cycles between bytes inside a frame before the frame is aborted
BUS_TIMEOUT, 1024, max cycles spent waiting on waitrequest or readdatavalid before an error response

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte, valid only with rx_valid
rx_valid  in  1  one-cycle strobe per received byte; no backpressure
tx_data  out  8  response byte
tx_valid  out  1  response byte valid; held until accepted
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
master_mm_address  out  32  register byte address
master_mm_write  out  1  write request
master_mm_writedata  out  32  write data
master_mm_read  out  1  read request
master_mm_readdata  in  32  read data
master_mm_readdatavalid  in  1  read data strobe
master_mm_waitrequest  in  1  slave stall
msg_done  out  1  one-cycle pulse per successful command; connects to blinker msg_enter
busy  out  1  high in any state other than IDLE
rx_drop  out  1  one-cycle pulse when an rx byte arrives in a non-receiving state

Behaviour:
- Reset: all outputs 0; FSM in IDLE; address, data, byte count and timers cleared. Reset mid-frame or mid-bus-cycle aborts immediately with no response.
- Frame format: CMD, ADDR[31:24], ADDR[23:16], ADDR[15:8], ADDR[7:0], then for writes D[31:24]..D[7:0]. Multi-byte fields are MSB first. CMD 0x57 = write, 0x52 = read.
- States: IDLE, ADDR, DATA, BUS_WR, BUS_RD, WAIT_RD, RESP.
- IDLE, rx byte:
  - 0x57 or 0x52: go to ADDR.
  - Any other value: load 0x45 into the response register and go to RESP.
- ADDR: shift 4 bytes into the address. After the 4th, go to DATA for a write or BUS_RD for a read.
- DATA: shift 4 bytes into writedata. After the 4th, go to BUS_WR.
- Inter-byte timer, ADDR/DATA only: counts cycles without rx_valid and resets on each byte. On reaching INTER_BYTE_TIMEOUT, return to IDLE silently with no response.
- BUS_WR:
  - master_mm_write=1 with address and writedata stable, held while waitrequest=1.
  - Accepted on a cycle with write=1 and waitrequest=0; deassert write the next cycle.
  - Response 0x4B; msg_done pulses on the cycle the FSM enters RESP.
- BUS_RD:
  - master_mm_read=1 held while waitrequest=1; on acceptance deassert read and go to WAIT_RD.
  - Also accept readdatavalid arriving in the acceptance cycle or any later cycle.
- WAIT_RD: on readdatavalid, capture readdata. Response is the 4 data bytes MSB first; msg_done pulses on entering RESP.
- Bus timer: counts cycles in BUS_WR, BUS_RD and WAIT_RD. On reaching BUS_TIMEOUT:
  - Drop read/write.
  - Ignore any later readdatavalid.
  - Response 0x45; no msg_done.
- RESP:
  - Present bytes in order; each held on tx_data with tx_valid=1 until tx_ready.
  - After the last byte is accepted, tx_valid goes 0 the next cycle and the FSM returns to IDLE.
  - tx_data is held stable while tx_valid=1.
- rx_valid in BUS_*, WAIT_RD or RESP: byte discarded and rx_drop pulses. rx_valid in the same cycle as a state exit into a receiving state is also discarded.
- Read and write are never asserted together. At most one transaction is outstanding.
- Address is passed through unmodified with no alignment check.

Optional Feature:
- Macro: UART_MM_CMD_BRIDGE_CHECKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte (state CSUM): the XOR of all preceding frame bytes, including CMD.
  - Mismatch: response 0x43, no bus transaction, no msg_done.
  - The inter-byte timeout also applies in CSUM.
- Undefined: no CSUM state; frames are exactly 5 (read) or 9 (write) bytes.

Test Plan:
- Write test register: rx 57 00 00 00 04 DE AD BE EF, slave waitrequest=1 for 3 cycles. Expect write held 4 cycles with address 0x4 and writedata 0xDEADBEEF, tx 0x4B, one msg_done pulse.
- Read back: rx 52 00 00 00 04, slave returns readdatavalid 1 cycle after acceptance with 0xDEADBEEF. Expect tx DE AD BE EF in order, with tx_ready low for 5 cycles on byte 2 and tx_data stable throughout.
- Unmapped read: rx 52 00 00 00 0C, no readdatavalid. Expect read deasserted, tx 0x45 exactly BUS_TIMEOUT cycles after entering BUS_RD, no msg_done.
- Bad command: rx 0x11 -> tx 0x45, no bus activity. Then rx 57 00 00 00 00 00 00 00 01 -> write address 0 data 0x1, tx 0x4B.
- Abort and drop: rx 57 00 00, then idle INTER_BYTE_TIMEOUT cycles. Expect busy=0, no tx, no bus cycle. Separately, rx_valid during RESP -> rx_drop pulse, response unaffected.
- Reset during BUS_WR with waitrequest stuck at 1: assert rst. Expect write, tx_valid, busy and msg_done all 0 immediately, then a normal read succeeds.
